// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory responder
//
// Contents:
//   memstate_t      responder FSM states (IDLE, WAIT, RESP)
//   BYTES_PER_WORD  byte lanes per 32-bit word
//   CNT_W           width of the wait-latency counter (LATENCY up to 15)
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} memstate_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/bewram.sv
// rtl/bewram.sv - word-organised RAM with byte-lane write enables
//
// Ports:
//   clk  in   write clock
//   we   in   write strobe
//   be   in   byte-lane enables, bit i selects wd[8i+7:8i]
//   a    in   word address
//   wd   in   write data
//   rd   out  read data, combinational from a
//
// Contents are not reset.
module bewram
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [BYTES_PER_WORD-1:0] be,
  input  logic [DEPTH_LOG2-1:0]     a,
  input  logic [31:0]               wd,
  output logic [31:0]               rd
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (be[i]) begin
          mem[a][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  assign rd = mem[a];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency load/store responder for the core's data port
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready from state and reset only)
//   req_we                1 = store, 0 = load
//   req_addr              byte address; must be word aligned and inside the RAM
//   req_wdata, req_be     store data and byte-lane enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data; 0 for stores and rejected accesses
//   rsp_err               access rejected (misaligned or out of range)
//
// Each accepted request spends LATENCY cycles in WAIT; the RAM is touched on
// the last WAIT edge, and the registered response is held in RESP until taken.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  memstate_t         state, state_nx;
  logic [CNT_W-1:0]  cnt;

  logic              cap_we;
  logic [31:0]       cap_addr;
  logic [31:0]       cap_wdata;
  logic [3:0]        cap_be;

  logic              accept;
  logic              fire;
  logic              addr_err;
  logic              mem_we;
  logic [31:0]       mem_rd;

  // Anything outside the RAM or not word aligned is rejected without side effects.
  assign addr_err = (cap_addr[1:0] != 2'b00) ||
                    ((cap_addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  assign accept = req_valid && req_ready;
  assign fire   = (state == WAIT) && (cnt == '0);
  // Gating with reset drops a store whose access edge coincides with reset.
  assign mem_we = fire && cap_we && !addr_err && !reset;

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_be    <= req_be;
        cnt       <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (fire) begin
        rsp_err   <= addr_err;
        rsp_rdata <= (addr_err || cap_we) ? 32'd0 : mem_rd;
      end
    end
  end

  bewram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk(clk),
    .we (mem_we),
    .be (cap_be),
    .a  (cap_addr[DEPTH_LOG2+1:2]),
    .wd (cap_wdata),
    .rd (mem_rd)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (LATENCY 2 and 1 instances)
module tb_mem_responder;

  logic        clk;
  logic [1:0]  reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata [2];
  logic [1:0]  rsp_err;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;

  // transaction-level model state per instance
  bit          busy      [2];
  int          acc       [2];
  bit [31:0]   xdata     [2];
  bit [31:0]   xmask     [2];
  bit          xerr      [2];
  bit          pw        [2];
  int          pidx      [2];
  bit [3:0]    pbe       [2];
  bit [31:0]   pwd       [2];
  bit          was_reset [2];
  bit [31:0]   mm        [2][64];
  bit [3:0]    kb        [2][64];

  mem_responder #(.DEPTH_LOG2(6), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.DEPTH_LOG2(6), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: advances on every rising edge from the bench-driven inputs only.
  initial begin
    forever begin
      @(posedge clk);
      edges++;
      for (int i = 0; i < 2; i++) begin
        if (reset[i]) begin
          busy[i]      = 1'b0;
          was_reset[i] = 1'b1;
        end else if (busy[i]) begin
          if (edges == acc[i] + lat_of(i)) begin
            was_reset[i] = 1'b0;
            if (pw[i]) begin
              for (int b = 0; b < 4; b++) begin
                if (pbe[i][b]) begin
                  mm[i][pidx[i]][8*b +: 8] = pwd[i][8*b +: 8];
                  kb[i][pidx[i]][b] = 1'b1;
                end
              end
            end
          end else if ((edges - 1 >= acc[i] + lat_of(i)) && rsp_ready[i]) begin
            busy[i] = 1'b0;
          end
        end else if (req_valid[i]) begin
          bit [31:0] a;
          bit        e;
          int        idx;
          a   = req_addr[i];
          e   = (a[1:0] != 2'b00) || ((a >> 8) != 32'd0);
          idx = int'(a[7:2]);
          busy[i] = 1'b1;
          acc[i]  = edges;
          xerr[i] = e;
          if (e || req_we[i]) begin
            xdata[i] = 32'd0;
            xmask[i] = 32'hFFFF_FFFF;
          end else begin
            xdata[i] = mm[i][idx];
            xmask[i] = 32'd0;
            for (int b = 0; b < 4; b++) begin
              if (kb[i][idx][b]) xmask[i][8*b +: 8] = 8'hFF;
            end
          end
          pw[i]   = req_we[i] && !e;
          pidx[i] = idx;
          pbe[i]  = req_be[i];
          pwd[i]  = req_wdata[i];
        end
      end
    end
  end

  // Compare: every falling edge, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit v;
        v = busy[i] && (edges >= acc[i] + lat_of(i));
        chk($sformatf("req_ready[%0d]", i), {31'd0, req_ready[i]}, {31'd0, !reset[i] && !busy[i]});
        chk($sformatf("rsp_valid[%0d]", i), {31'd0, rsp_valid[i]}, {31'd0, v});
        if (v) begin
          chk($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i] & xmask[i], xdata[i] & xmask[i]);
          chk($sformatf("rsp_err[%0d]", i), {31'd0, rsp_err[i]}, {31'd0, xerr[i]});
        end
        if (was_reset[i]) begin
          chk($sformatf("rst_rdata[%0d]", i), rsp_rdata[i], 32'd0);
          chk($sformatf("rst_err[%0d]", i), {31'd0, rsp_err[i]}, 32'd0);
        end
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  // Issue one access from inside a drive window; returns in the window after the handshake.
  task automatic access(input int i, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output bit err, output int lat,
                        output int acc_e);
    int guard;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_be[i]    = be;
    rdata = 32'd0; err = 1'b0; lat = -1; acc_e = -1;
    guard = 0;
    while (!req_ready[i] && guard < 40) begin
      step;
      guard++;
    end
    if (guard >= 40) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid[i] = 1'b0;
      return;
    end
    acc_e = edges + 1;
    step;
    req_valid[i] = 1'b0;
    guard = 0;
    while (!rsp_valid[i] && guard < 40) begin
      step;
      guard++;
    end
    if (guard >= 40) begin
      chk("rsp_timeout", 32'd1, 32'd0);
      return;
    end
    lat   = edges - acc_e;
    rdata = rsp_rdata[i];
    err   = rsp_err[i];
    for (int h = 0; h < hold; h++) begin
      step;
      chk("bp_valid", {31'd0, rsp_valid[i]}, 32'd1);
      chk("bp_rdata", rsp_rdata[i], rdata);
      chk("bp_err", {31'd0, rsp_err[i]}, {31'd0, err});
      chk("bp_req_ready", {31'd0, req_ready[i]}, 32'd0);
    end
    rsp_ready[i] = 1'b1;
    step;
    rsp_ready[i] = 1'b0;
    chk("post_hs_ready", {31'd0, req_ready[i]}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit          er;
    int          lt, ae, prev_ae;
    logic [31:0] a, d;

    reset     = 2'b11;
    req_valid = 2'b00;
    req_we    = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      req_be[i]    = 4'd0;
    end
    repeat (3) step;
    chk("reset_req_ready", {31'd0, req_ready[0]}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata[0], 32'd0);
    reset = 2'b00;
    step;
    chk("first_ready", {31'd0, req_ready[0]}, 32'd1);

    // seed words used later
    access(0, 1'b1, 32'h0,  32'h0123_4567, 4'hF, 0, rd, er, lt, ae);
    access(0, 1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, 0, rd, er, lt, ae);

    access(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lt, ae);
    chk("store8_err", {31'd0, er}, 32'd0);
    chk("store8_rdata", rd, 32'd0);
    chk("store8_lat", lt, 32'd2);
    access(0, 1'b0, 32'h8, 32'd0, 4'h0, 0, rd, er, lt, ae);
    chk("load8_rdata", rd, 32'hDEAD_BEEF);
    chk("load8_lat", lt, 32'd2);

    access(0, 1'b1, 32'h8, 32'h1122_3344, 4'b0101, 0, rd, er, lt, ae);
    access(0, 1'b0, 32'h8, 32'd0, 4'h0, 0, rd, er, lt, ae);
    chk("partial_rdata", rd, 32'hDE22_BE44);

    access(0, 1'b0, 32'h6, 32'd0, 4'hF, 0, rd, er, lt, ae);
    chk("misalign_err", {31'd0, er}, 32'd1);
    chk("misalign_rdata", rd, 32'd0);

    access(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lt, ae);
    chk("range_err", {31'd0, er}, 32'd1);
    access(0, 1'b0, 32'h0, 32'd0, 4'h0, 0, rd, er, lt, ae);
    chk("range_no_write", rd, 32'h0123_4567);

    access(0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lt, ae);
    chk("be0_err", {31'd0, er}, 32'd0);
    access(0, 1'b0, 32'h8, 32'd0, 4'h0, 0, rd, er, lt, ae);
    chk("be0_unchanged", rd, 32'hDE22_BE44);

    access(0, 1'b0, 32'h0, 32'd0, 4'h0, 5, rd, er, lt, ae);
    chk("bp_load_rdata", rd, 32'h0123_4567);

    // reset while a store sits in WAIT
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'hCAFE_F00D;
    req_be[0]    = 4'hF;
    chk("mid_ready", {31'd0, req_ready[0]}, 32'd1);
    step;
    req_valid[0] = 1'b0;
    reset[0] = 1'b1;
    step;
    chk("mid_rst_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("mid_rst_rdata", rsp_rdata[0], 32'd0);
    chk("mid_rst_err", {31'd0, rsp_err[0]}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready[0]}, 32'd0);
    step;
    reset[0] = 1'b0;
    step;
    access(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er, lt, ae);
    chk("mid_rst_nowrite", rd, 32'h0BAD_F00D);

    // LATENCY=1 back-to-back store/load pairs
    prev_ae = -1;
    for (int k = 0; k < 4; k++) begin
      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      d = $urandom;
      access(1, 1'b1, a, d, 4'hF, 0, rd, er, lt, ae);
      chk("l1_store_lat", lt, 32'd1);
      chk("l1_store_err", {31'd0, er}, 32'd0);
      if (prev_ae >= 0) chk("l1_spacing", ae - prev_ae, 32'd3);
      prev_ae = ae;
      access(1, 1'b0, a, 32'd0, 4'h0, 0, rd, er, lt, ae);
      chk("l1_load_lat", lt, 32'd1);
      chk("l1_load_rdata", rd, d);
      chk("l1_spacing", ae - prev_ae, 32'd3);
      prev_ae = ae;
    end

    repeat (2) step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
